piso_serial_sched: RTL and testbench

Round-robin scheduler that shares one parallel-in serial-out shift datapath between two parallel word sources. It accepts words over valid/ready, loads the shift register, and sequences the shift. It presents the word MSB-first as a serial stream with its own valid/ready handshake and a last-bit marker. It sits between the parallel producers and the serial link.

---
 rtl/piso_sched_pkg.sv | 20 ++
 rtl/piso_shift_reg.sv | 29 ++
 rtl/piso_serial_sched.sv | 160 ++++++++++++++++
 tb/tb_piso_serial_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_sched_pkg.sv
// Shared types and helpers for the piso_serial_sched block.
// The state enum always lists SHIFT_PAR; it is only reachable when the
// block is built with PISO_SCHED_PARITY_EN defined.
package piso_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        SHIFT_PAR = 2'd2
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Width of the bit counter: it must hold WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load, shift-left register; MSB is the serial bit.
// A load takes priority over a shift in the same cycle.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    // Load a fresh word or advance the frame by one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift_en) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/piso_serial_sched.sv
// Round-robin scheduler sharing one PISO datapath between two sources.
// Frames go out MSB-first with a valid/ready handshake and last marker.
// Optional even-parity trailer bit: define PISO_SCHED_PARITY_EN.
module piso_serial_sched
    import piso_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             ser_data_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    input  logic             ser_ready_i,
    output logic             grant_id_o
);

    localparam int CW = cnt_w(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("piso_serial_sched: WIDTH must be 2..16");
        end
    endgenerate

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic             rr_ptr;
    logic             sr_msb;
    logic             accept_slot;
    logic             any_valid;
    logic             gnt_id;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] load_data;
`ifdef PISO_SCHED_PARITY_EN
    logic             parity;
`endif

    // Accept slot: idle, or the final bit of the frame is being consumed.
    // Gated by rst_n so ready stays low while reset is asserted.
    always_comb begin
        accept_slot = 1'b0;
        if (rst_n) begin
`ifdef PISO_SCHED_PARITY_EN
            accept_slot = (state == IDLE) ||
                          (state == SHIFT_PAR && ser_ready_i);
`else
            accept_slot = (state == IDLE) ||
                          (state == SHIFT && ser_ready_i && bit_cnt == '0);
`endif
        end
    end

    // Round-robin pick: preferred source wins a tie, a lone source always wins.
    always_comb begin
        any_valid = req0_valid_i | req1_valid_i;
        gnt_id    = SRC0;
        if (req1_valid_i && (!req0_valid_i || rr_ptr == SRC1)) begin
            gnt_id = SRC1;
        end
        load         = accept_slot & any_valid;
        req0_ready_o = load & (gnt_id == SRC0);
        req1_ready_o = load & (gnt_id == SRC1);
        load_data    = (gnt_id == SRC1) ? req1_data_i : req0_data_i;
        shift_en     = (state == SHIFT) & ser_ready_i;
    end

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .shift_en  (shift_en),
        .msb       (sr_msb)
    );

`ifdef PISO_SCHED_PARITY_EN
    assign ser_data_o = (state == SHIFT_PAR) ? parity : sr_msb;
`else
    assign ser_data_o = sr_msb;
`endif

    // Frame sequencer: load/arbitrate, count bits, drive valid and last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rr_ptr      <= SRC0;
            grant_id_o  <= SRC0;
            ser_valid_o <= 1'b0;
            ser_last_o  <= 1'b0;
`ifdef PISO_SCHED_PARITY_EN
            parity      <= 1'b0;
`endif
        end else if (load) begin
            state       <= SHIFT;
            bit_cnt     <= CW'(WIDTH - 1);
            grant_id_o  <= gnt_id;
            rr_ptr      <= ~gnt_id;
            ser_valid_o <= 1'b1;
            ser_last_o  <= 1'b0;
`ifdef PISO_SCHED_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ser_valid_o <= 1'b0;
                    ser_last_o  <= 1'b0;
                end
                SHIFT: begin
                    if (ser_ready_i) begin
`ifdef PISO_SCHED_PARITY_EN
                        parity <= parity ^ sr_msb;
`endif
                        if (bit_cnt == '0) begin
`ifdef PISO_SCHED_PARITY_EN
                            state      <= SHIFT_PAR;
                            ser_last_o <= 1'b1;
`else
                            state       <= IDLE;
                            ser_valid_o <= 1'b0;
                            ser_last_o  <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
`ifndef PISO_SCHED_PARITY_EN
                            ser_last_o <= (bit_cnt == CW'(1));
`endif
                        end
                    end
                end
`ifdef PISO_SCHED_PARITY_EN
                SHIFT_PAR: begin
                    if (ser_ready_i) begin
                        state       <= IDLE;
                        ser_valid_o <= 1'b0;
                        ser_last_o  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state       <= IDLE;
                    ser_valid_o <= 1'b0;
                    ser_last_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_sched.sv
// Self-checking bench for piso_serial_sched (WIDTH=4).
// Directed scenarios plus a randomized run against a frame-queue model.
module tb_piso_serial_sched;

    localparam int W = 4;
`ifdef PISO_SCHED_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         r0, r1;
    logic         sdata, svalid, slast, gid;
    logic         sready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic d; logic l; logic s;} sbit_t;
    sbit_t q[$];
    logic  mptr;

    always #5 clk = ~clk;

    piso_serial_sched #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (v0),
        .req0_data_i  (d0),
        .req0_ready_o (r0),
        .req1_valid_i (v1),
        .req1_data_i  (d1),
        .req1_ready_o (r1),
        .ser_data_o   (sdata),
        .ser_valid_o  (svalid),
        .ser_last_o   (slast),
        .ser_ready_i  (sready),
        .grant_id_o   (gid)
    );

    // Bit b of a frame carrying word d: data MSB-first, then even parity.
    function automatic logic fbit(input logic [W-1:0] d, input int b);
        if (b < W) return d[W-1-b];
        return ^d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; v0 = 0; v1 = 0; d0 = '0; d1 = '0; sready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v0 = 1; v1 = 1; sready = 1;
        #1;
        checks += 6;
        if (sdata !== 1'b0)  begin errors++; $display("FAIL reset_data got %b exp 0", sdata); end
        if (svalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", svalid); end
        if (slast !== 1'b0)  begin errors++; $display("FAIL reset_last got %b exp 0", slast); end
        if (r0 !== 1'b0)     begin errors++; $display("FAIL reset_ready0 got %b exp 0", r0); end
        if (r1 !== 1'b0)     begin errors++; $display("FAIL reset_ready1 got %b exp 0", r1); end
        if (gid !== 1'b0)    begin errors++; $display("FAIL reset_grant got %b exp 0", gid); end
        tick();
        checks++;
        if (svalid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %b exp 0", svalid); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        v0 = 1; d0 = 4'b1011; sready = 1;
        #1;
        checks += 3;
        if (r0 !== 1'b1)     begin errors++; $display("FAIL single_ready0 got %b exp 1", r0); end
        if (r1 !== 1'b0)     begin errors++; $display("FAIL single_ready1 got %b exp 0", r1); end
        if (svalid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", svalid); end
        tick();
        v0 = 0;
        for (int b = 0; b < FLEN; b++) begin
            #1;
            checks += 4;
            if (svalid !== 1'b1) begin errors++; $display("FAIL single_valid b%0d got %b exp 1", b, svalid); end
            if (sdata !== fbit(d0, b)) begin errors++; $display("FAIL single_data b%0d got %b exp %b", b, sdata, fbit(d0, b)); end
            if (slast !== (b == FLEN-1)) begin errors++; $display("FAIL single_last b%0d got %b exp %b", b, slast, (b == FLEN-1)); end
            if (gid !== 1'b0) begin errors++; $display("FAIL single_grant b%0d got %b exp 0", b, gid); end
            tick();
        end
        #1;
        checks++;
        if (svalid !== 1'b0) begin errors++; $display("FAIL single_end_idle got %b exp 0", svalid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] wd;
        int f, b;
        apply_reset();
        v0 = 1; v1 = 1; d0 = 4'b1100; d1 = 4'b0011; sready = 1;
        #1;
        checks += 2;
        if (r0 !== 1'b1) begin errors++; $display("FAIL b2b_first_ready0 got %b exp 1", r0); end
        if (r1 !== 1'b0) begin errors++; $display("FAIL b2b_first_ready1 got %b exp 0", r1); end
        tick();
        for (int c = 0; c < 4*FLEN; c++) begin
            f = c / FLEN;
            b = c % FLEN;
            wd = (f % 2 == 1) ? d1 : d0;
            #1;
            checks += 5;
            if (svalid !== 1'b1) begin errors++; $display("FAIL b2b_valid c%0d got %b exp 1", c, svalid); end
            if (gid !== 1'((f % 2))) begin errors++; $display("FAIL b2b_grant c%0d got %b exp %0d", c, gid, f % 2); end
            if (sdata !== fbit(wd, b)) begin errors++; $display("FAIL b2b_data c%0d got %b exp %b", c, sdata, fbit(wd, b)); end
            if (r0 !== (b == FLEN-1 && (f+1) % 2 == 0)) begin errors++; $display("FAIL b2b_ready0 c%0d got %b", c, r0); end
            if (r1 !== (b == FLEN-1 && (f+1) % 2 == 1)) begin errors++; $display("FAIL b2b_ready1 c%0d got %b", c, r1); end
            tick();
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_backpressure();
        int n, idx;
        logic done;
        apply_reset();
        v0 = 1; d0 = 4'b1010; sready = 1;
        #1;
        tick();
        v0 = 0;
        n = 0; done = 0;
        while (!done && n < 20) begin
            sready = !(n >= 1 && n <= 3);
            idx = (n == 0) ? 0 : ((n <= 4) ? 1 : n - 3);
            #1;
            checks += 2;
            if (svalid !== 1'b1) begin errors++; $display("FAIL bp_valid n%0d got %b exp 1", n, svalid); end
            if (sdata !== fbit(d0, idx)) begin errors++; $display("FAIL bp_data n%0d got %b exp %b", n, sdata, fbit(d0, idx)); end
            if (n >= 1 && n <= 3) begin
                checks++;
                if (slast !== 1'b0) begin errors++; $display("FAIL bp_last_hold n%0d got %b exp 0", n, slast); end
            end
            if (svalid && sready && slast) done = 1;
            n++;
            tick();
        end
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
        if (n != FLEN + 3) begin errors++; $display("FAIL bp_cycles got %0d exp %0d", n, FLEN + 3); end
        sready = 1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        v0 = 1; d0 = 4'b1011; sready = 1;
        #1;
        tick();
        v0 = 0;
        tick();
        tick();
        v1 = 1; d1 = 4'b0110;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (svalid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", svalid); end
        if (sdata !== 1'b0)  begin errors++; $display("FAIL rmid_data got %b exp 0", sdata); end
        if (slast !== 1'b0)  begin errors++; $display("FAIL rmid_last got %b exp 0", slast); end
        if (r1 !== 1'b0)     begin errors++; $display("FAIL rmid_ready1 got %b exp 0", r1); end
        if (gid !== 1'b0)    begin errors++; $display("FAIL rmid_grant got %b exp 0", gid); end
        tick();
        rst_n = 1'b1;
        #1;
        checks += 3;
        if (r1 !== 1'b1)     begin errors++; $display("FAIL rmid_rel_ready1 got %b exp 1", r1); end
        if (r0 !== 1'b0)     begin errors++; $display("FAIL rmid_rel_ready0 got %b exp 0", r0); end
        if (svalid !== 1'b0) begin errors++; $display("FAIL rmid_rel_valid got %b exp 0", svalid); end
        tick();
        v1 = 0;
        for (int b = 0; b < FLEN; b++) begin
            #1;
            checks += 3;
            if (svalid !== 1'b1) begin errors++; $display("FAIL rmid_f_valid b%0d got %b exp 1", b, svalid); end
            if (sdata !== fbit(d1, b)) begin errors++; $display("FAIL rmid_f_data b%0d got %b exp %b", b, sdata, fbit(d1, b)); end
            if (gid !== 1'b1) begin errors++; $display("FAIL rmid_f_grant b%0d got %b exp 1", b, gid); end
            tick();
        end
    endtask

    task automatic test_src1_alone();
        apply_reset();
        v1 = 1; d1 = 4'b1001; sready = 1;
        #1;
        checks += 2;
        if (r1 !== 1'b1) begin errors++; $display("FAIL s1_ready1 got %b exp 1", r1); end
        if (r0 !== 1'b0) begin errors++; $display("FAIL s1_ready0 got %b exp 0", r0); end
        tick();
        v0 = 1; d0 = 4'b0101;
        for (int b = 0; b < FLEN; b++) begin
            #1;
            checks += 4;
            if (gid !== 1'b1) begin errors++; $display("FAIL s1_grant b%0d got %b exp 1", b, gid); end
            if (sdata !== fbit(d1, b)) begin errors++; $display("FAIL s1_data b%0d got %b exp %b", b, sdata, fbit(d1, b)); end
            if (r0 !== (b == FLEN-1)) begin errors++; $display("FAIL s1_tie_ready0 b%0d got %b exp %b", b, r0, (b == FLEN-1)); end
            if (r1 !== 1'b0) begin errors++; $display("FAIL s1_tie_ready1 b%0d got %b exp 0", b, r1); end
            tick();
        end
        #1;
        checks += 2;
        if (gid !== 1'b0) begin errors++; $display("FAIL s1_next_grant got %b exp 0", gid); end
        if (sdata !== fbit(d0, 0)) begin errors++; $display("FAIL s1_next_data got %b exp %b", sdata, fbit(d0, 0)); end
        v0 = 0; v1 = 0;
    endtask

`ifdef PISO_SCHED_PARITY_EN
    task automatic test_parity();
        logic [4:0] exp_bits;
        apply_reset();
        exp_bits = 5'b01111;
        v0 = 1; d0 = 4'b0111; sready = 1;
        #1;
        tick();
        v0 = 0;
        for (int b = 0; b < 5; b++) begin
            #1;
            checks += 2;
            if (sdata !== exp_bits[4-b]) begin errors++; $display("FAIL par_data b%0d got %b exp %b", b, sdata, exp_bits[4-b]); end
            if (slast !== (b == 4)) begin errors++; $display("FAIL par_last b%0d got %b exp %b", b, slast, (b == 4)); end
            tick();
        end
        #1;
        checks++;
        if (svalid !== 1'b0) begin errors++; $display("FAIL par_end_idle got %b exp 0", svalid); end
    endtask
`endif

    // Model: queue of bits still owed to the sink; grants appended as whole frames.
    task automatic test_random();
        logic exp_v, slot, has_g, g;
        sbit_t e;
        logic [W-1:0] wd;
        apply_reset();
        q.delete();
        mptr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            d0 = W'($urandom);
            d1 = W'($urandom);
            sready = ($urandom_range(0, 3) != 0);
            #1;
            exp_v = (q.size() > 0);
            checks++;
            if (svalid !== exp_v) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, svalid, exp_v); end
            if (exp_v) begin
                e = q[0];
                checks += 3;
                if (sdata !== e.d) begin errors++; $display("FAIL rnd_data c%0d got %b exp %b", c, sdata, e.d); end
                if (slast !== e.l) begin errors++; $display("FAIL rnd_last c%0d got %b exp %b", c, slast, e.l); end
                if (gid !== e.s)   begin errors++; $display("FAIL rnd_grant c%0d got %b exp %b", c, gid, e.s); end
            end
            slot  = (q.size() == 0) || (q.size() == 1 && sready);
            has_g = slot && (v0 || v1);
            g     = (v0 && v1) ? mptr : v1;
            checks += 2;
            if (r0 !== (has_g && !g)) begin errors++; $display("FAIL rnd_ready0 c%0d got %b exp %b", c, r0, has_g && !g); end
            if (r1 !== (has_g && g))  begin errors++; $display("FAIL rnd_ready1 c%0d got %b exp %b", c, r1, has_g && g); end
            if (exp_v && sready) void'(q.pop_front());
            if (has_g) begin
                wd = g ? d1 : d0;
                for (int b = 0; b < FLEN; b++) begin
                    e.d = fbit(wd, b);
                    e.l = (b == FLEN-1);
                    e.s = g;
                    q.push_back(e);
                end
                mptr = ~g;
            end
            tick();
        end
        v0 = 0; v1 = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_src1_alone();
`ifdef PISO_SCHED_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
